servo_pose_replayer: RTL

- Reader end of the servo pose bus written by the keyboard data controller.
- Records snapshots of the four live servo pulse-width values on the record key, and on the replay key plays them back in order.
- During playback it drives the servo outputs with rate-limited motion toward each stored pose, then dwells at that pose.
- Sits between the data controller's servo0..3 bus and the PWM output stage, and runs on the same controller tick.

---
 rtl/servo_pkg.sv | 43 ++++
 rtl/pose_ram.sv | 24 ++
 rtl/servo_pose_replayer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// Shared constants, FSM encoding and the step-toward-target helper
// for the servo pose replayer.
package servo_pkg;

    localparam int SERVO_W = 13;
    localparam logic [SERVO_W-1:0] SERVO_DEFAULT = 13'd150;
    localparam logic [SERVO_W-1:0] SERVO_STEP = 13'd5;
    localparam logic [SERVO_W-1:0] SERVO_LOWER = 13'd50;
    localparam logic [SERVO_W-1:0] SERVO_UPPER = 13'd965;

    localparam int KB_W = 0;
    localparam int KB_A = 1;
    localparam int KB_S = 2;
    localparam int KB_D = 3;
    localparam int KB_UP = 4;
    localparam int KB_DOWN = 5;
    localparam int KB_LEFT = 6;
    localparam int KB_RIGHT = 7;
    localparam int KB_SPACE = 8;
    localparam int KB_ENTER = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Signed 14-bit difference keeps the move exact: no overshoot, no wrap.
    function automatic logic [SERVO_W-1:0] step_toward(
        input logic [SERVO_W-1:0] cur,
        input logic [SERVO_W-1:0] tgt,
        input logic [SERVO_W-1:0] step
    );
        logic signed [SERVO_W:0] diff;
        logic signed [SERVO_W:0] lim;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        lim = $signed({1'b0, step});
        if (diff <= lim && diff >= -lim) return tgt;
        if (diff > 0) return cur + step;
        return cur - step;
    endfunction

endpackage

// File: rtl/pose_ram.sv
// Pose storage: synchronous write, asynchronous read.
// Contents are deliberately left unreset.
module pose_ram #(
    parameter int DEPTH = 16,
    parameter int W = 52,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/servo_pose_replayer.sv
// Records servo pose snapshots on the record key and replays them
// with rate-limited motion and a dwell at each pose.
module servo_pose_replayer
    import servo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int STEP = 5,
    parameter int HOLD_TICKS = 20
) (
    input  logic               controller_clk,
    input  logic               i_rst_n,
    input  logic               i_record,
    input  logic               i_replay,
    input  logic [SERVO_W-1:0] i_servo0,
    input  logic [SERVO_W-1:0] i_servo1,
    input  logic [SERVO_W-1:0] i_servo2,
    input  logic [SERVO_W-1:0] i_servo3,
    output logic [SERVO_W-1:0] o_servo0,
    output logic [SERVO_W-1:0] o_servo1,
    output logic [SERVO_W-1:0] o_servo2,
    output logic [SERVO_W-1:0] o_servo3,
    output logic               o_replaying,
    output logic [4:0]         o_tot_state,
    output logic [4:0]         o_current_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = $clog2(HOLD_TICKS);
    localparam logic [HW-1:0] HOLD_END = HW'(HOLD_TICKS - 1);
    localparam logic [SERVO_W-1:0] STEP_V = SERVO_W'(STEP);

    state_t state;
    logic rec_prev;
    logic rep_prev;
    logic [4:0] tot;
    logic [4:0] cur_idx;
    logic [HW-1:0] hold_cnt;
    logic [SERVO_W-1:0] srv [4];
    logic [SERVO_W-1:0] live [4];
    logic [SERVO_W-1:0] tgt [4];
    logic [4*SERVO_W-1:0] rdata;
    logic rec_evt;
    logic rep_evt;
    logic full;
    logic last;
    logic we;
    logic at_tgt;

    assign live[0] = i_servo0;
    assign live[1] = i_servo1;
    assign live[2] = i_servo2;
    assign live[3] = i_servo3;
    assign {tgt[3], tgt[2], tgt[1], tgt[0]} = rdata;

    assign rec_evt = i_record & ~rec_prev;
    assign rep_evt = i_replay & ~rep_prev;
    assign full = (tot == 5'(DEPTH));
    assign last = (cur_idx == tot - 5'd1);
    assign we = (state == IDLE) && rec_evt && !full;
    assign at_tgt = (srv[0] == tgt[0]) && (srv[1] == tgt[1])
                 && (srv[2] == tgt[2]) && (srv[3] == tgt[3]);

    pose_ram #(
        .DEPTH(DEPTH),
        .W    (4 * SERVO_W)
    ) u_ram (
        .clk  (controller_clk),
        .we   (we),
        .waddr(tot[AW-1:0]),
        .wdata({i_servo3, i_servo2, i_servo1, i_servo0}),
        .raddr(cur_idx[AW-1:0]),
        .rdata(rdata)
    );

    always_ff @(posedge controller_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            rec_prev <= 1'b0;
            rep_prev <= 1'b0;
            tot <= '0;
            cur_idx <= '0;
            hold_cnt <= '0;
            o_replaying <= 1'b0;
            for (int i = 0; i < 4; i++) srv[i] <= SERVO_DEFAULT;
        end else begin
            rec_prev <= i_record;
            rep_prev <= i_replay;
            unique case (state)
                IDLE: begin
                    if (rec_evt) begin
                        if (!full) tot <= tot + 5'd1;
                        for (int i = 0; i < 4; i++) srv[i] <= live[i];
                    end else if (rep_evt && tot != '0) begin
                        cur_idx <= '0;
                        o_replaying <= 1'b1;
                        state <= MOVE;
                    end else begin
                        for (int i = 0; i < 4; i++) srv[i] <= live[i];
                    end
                end
                MOVE: begin
                    if (rep_evt) begin
                        o_replaying <= 1'b0;
                        cur_idx <= '0;
                        state <= IDLE;
                    end else begin
                        for (int i = 0; i < 4; i++)
                            srv[i] <= step_toward(srv[i], tgt[i], STEP_V);
                        if (at_tgt) begin
                            hold_cnt <= '0;
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (rep_evt) begin
                        o_replaying <= 1'b0;
                        cur_idx <= '0;
                        hold_cnt <= '0;
                        state <= IDLE;
                    end else if (hold_cnt == HOLD_END) begin
                        hold_cnt <= '0;
                        if (!last) begin
                            cur_idx <= cur_idx + 5'd1;
                            state <= MOVE;
                        end else begin
                            o_replaying <= 1'b0;
                            cur_idx <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_servo0 = srv[0];
    assign o_servo1 = srv[1];
    assign o_servo2 = srv[2];
    assign o_servo3 = srv[3];
    assign o_tot_state = tot;
    assign o_current_state = cur_idx;

endmodule
